// File: rtl/bsg_link_pkg.sv
// Shared definitions for the BSG source-synchronous link (transmitter and receiver side).
// Holds the link geometry, the transmit FSM state type and the credit-counter width helper.
// Imported by bsg_upstream_tx and bsg_link_credit_cnt.
package bsg_link_pkg;

  localparam int IO_W   = 8;
  localparam int BEATS  = 4;
  localparam int CORE_W = IO_W * BEATS;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_e;

  // Bits needed to hold every value from 0 to credits inclusive
  function automatic int credit_width(input int credits);
    return $clog2(credits + 1);
  endfunction

endpackage

// File: rtl/bsg_link_credit_cnt.sv
// Purpose: link credit counter; dec on word send, inc on token return, saturating at CREDITS.
// Latency: count_o/zero_o reflect dec_i/inc_i one cycle later; overflow_o is combinational.
// Backpressure: none; caller gates dec_i with !zero_o, overflow_o pulses on a token into a full counter.
module bsg_link_credit_cnt
  import bsg_link_pkg::*;
#(
  parameter int CREDITS  = 32,
  parameter int CREDIT_W = credit_width(CREDITS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                dec_i,
  input  logic                inc_i,
  output logic [CREDIT_W-1:0] count_o,
  output logic                zero_o,
  output logic                overflow_o
);

  localparam logic [CREDIT_W-1:0] FULL = CREDIT_W'(CREDITS);
  localparam logic [CREDIT_W-1:0] ONE  = CREDIT_W'(1);

  logic [CREDIT_W-1:0] count_q, count_d;
  logic                dec_ok;

  // Next count: a dec and inc in the same cycle cancel; never wraps in either direction
  always_comb begin
    dec_ok     = dec_i && (count_q != '0);
    count_d    = count_q;
    overflow_o = 1'b0;
    if (dec_ok && !inc_i) begin
      count_d = count_q - ONE;
    end else if (inc_i && !dec_ok) begin
      if (count_q == FULL) begin
        overflow_o = 1'b1;
      end else begin
        count_d = count_q + ONE;
      end
    end
  end

  // Count register, restored to full credit on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= FULL;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/bsg_upstream_tx.sv
// Purpose: upstream link transmitter; serialises CORE_W core words into BEATS link beats, low byte first.
// Latency: beat 0 on the cycle after accept, one beat per cycle, back-to-back words with no bubbles.
// Backpressure: core_ready_out needs the last beat (or idle) and a credit; io_token_in returns one credit per word.
// Optional: define BSG_UPSTREAM_TX_STALL_CNT_EN to add stall_cnt, counting cycles offered with zero credit.
module bsg_upstream_tx
  import bsg_link_pkg::*;
#(
  parameter int CORE_W   = bsg_link_pkg::CORE_W,
  parameter int IO_W     = bsg_link_pkg::IO_W,
  parameter int BEATS    = bsg_link_pkg::BEATS,
  parameter int CREDITS  = 32,
  parameter int CREDIT_W = credit_width(CREDITS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_valid_in,
  input  logic [CORE_W-1:0] core_data_in,
  output logic              core_ready_out,
  output logic              io_valid_out,
  output logic [IO_W-1:0]   io_data_out,
  input  logic              io_token_in,
`ifdef BSG_UPSTREAM_TX_STALL_CNT_EN
  output logic [15:0]       stall_cnt,
`endif
  output logic              credit_err
);

  localparam int                    BEAT_CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_CNT_W-1:0] LAST_BEAT  = BEAT_CNT_W'(BEATS - 1);

  tx_state_e                  state_q, state_d;
  logic [BEAT_CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
  logic [CORE_W-1:0]          hold_q;
  logic [BEATS-1:0][IO_W-1:0] word_d;
  logic [IO_W-1:0]            io_data_q;
  logic                       credit_err_q;
  logic                       accept;
  logic                       last_beat;
  logic                       credit_zero;
  logic                       credit_ovf;
  logic [CREDIT_W-1:0]        credit_cnt;

  assign last_beat = (beat_cnt_q == LAST_BEAT);
  assign accept    = core_valid_in && core_ready_out;

  // One credit is reserved per word at accept time and returned by each token
  bsg_link_credit_cnt #(
    .CREDITS  (CREDITS),
    .CREDIT_W (CREDIT_W)
  ) u_credit (
    .clk        (clk),
    .rst        (rst),
    .dec_i      (accept),
    .inc_i      (io_token_in),
    .count_o    (credit_cnt),
    .zero_o     (credit_zero),
    .overflow_o (credit_ovf)
  );

  // FSM state and beat index registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Next state: walk the beats, chaining straight into a new word accepted on the last beat
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d    = SEND;
          beat_cnt_d = '0;
        end
      end
      SEND: begin
        if (last_beat) begin
          state_d    = accept ? SEND : IDLE;
          beat_cnt_d = '0;
        end else begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d    = IDLE;
        beat_cnt_d = '0;
      end
    endcase
  end

  // Outputs: ready comes from registered state and credit only, never from core_valid_in
  always_comb begin
    core_ready_out = ((state_q == IDLE) || last_beat) && !credit_zero && !rst;
    io_valid_out   = (state_q == SEND);
  end

  // The next beat comes from the word being accepted now, otherwise from the held word
  assign word_d = accept ? core_data_in : hold_q;

  // Hold register captures each accepted word
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
    end else if (accept) begin
      hold_q <= core_data_in;
    end
  end

  // Beat register loads the byte shown next cycle; it keeps its last value while idle
  always_ff @(posedge clk) begin
    if (rst) begin
      io_data_q <= '0;
    end else if (state_d == SEND) begin
      io_data_q <= word_d[beat_cnt_d];
    end
  end

  assign io_data_out = io_data_q;

  // Sticky error: a token arrived while every credit was already home
  always_ff @(posedge clk) begin
    if (rst) begin
      credit_err_q <= 1'b0;
    end else if (credit_ovf) begin
      credit_err_q <= 1'b1;
    end
  end

  assign credit_err = credit_err_q;

  // Credits can never exceed the receiver buffer capacity
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (credit_cnt <= CREDIT_W'(CREDITS));
    end
  end

`ifdef BSG_UPSTREAM_TX_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  // Count cycles where the core offers a word but no credit is available, saturating
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (core_valid_in && credit_zero && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_bsg_upstream_tx.sv
// Bench for bsg_upstream_tx: directed scenarios plus random traffic against a word/credit model.
// Expected beats are queued at accept and popped by a monitor on every falling edge.
// Builds with or without BSG_UPSTREAM_TX_STALL_CNT_EN.
module tb_bsg_upstream_tx;

  localparam int CREDITS = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_valid_in;
  logic [31:0] core_data_in;
  logic        core_ready_out;
  logic        io_valid_out;
  logic [7:0]  io_data_out;
  logic        io_token_in;
  logic        credit_err;
`ifdef BSG_UPSTREAM_TX_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  bsg_upstream_tx dut (
    .clk            (clk),
    .rst            (rst),
    .core_valid_in  (core_valid_in),
    .core_data_in   (core_data_in),
    .core_ready_out (core_ready_out),
    .io_valid_out   (io_valid_out),
    .io_data_out    (io_data_out),
    .io_token_in    (io_token_in),
`ifdef BSG_UPSTREAM_TX_STALL_CNT_EN
    .stall_cnt      (stall_cnt),
`endif
    .credit_err     (credit_err)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0] exp_q[$];
  int         credits   = CREDITS;
  bit         err_pend  = 1'b0;
  bit         err_vis   = 1'b0;
  int         stall_m   = 0;
  int         stall_vis = 0;
  logic [7:0] last_byte = 8'h00;
  bit         last_acc  = 1'b0;
  bit         mon_en    = 1'b0;
  int         tests     = 0;
  int         fails     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check ready against the model, advance the model
  task automatic step(input bit v, input logic [31:0] d, input bit tok, input bit r);
    bit exp_rdy;
    bit acc;
    int c;
    core_valid_in = v;
    core_data_in  = d;
    io_token_in   = tok;
    rst           = r;
    #1;
    // The link takes a new word only when at most the current beat remains and a credit exists
    exp_rdy = !r && (credits > 0) && (exp_q.size() <= 1);
    chk("core_ready", {31'd0, core_ready_out}, {31'd0, exp_rdy});
    acc      = v && exp_rdy;
    last_acc = acc;
    if (!r && v && credits == 0 && stall_m < 65535) stall_m++;
    c = credits - (acc ? 1 : 0) + (tok ? 1 : 0);
    if (c > CREDITS) begin
      c        = CREDITS;
      err_pend = 1'b1;
    end
    credits = c;
    @(posedge clk);
    #1;
    if (r) begin
      exp_q.delete();
      credits   = CREDITS;
      err_pend  = 1'b0;
      last_byte = 8'h00;
      stall_m   = 0;
    end else if (acc) begin
      for (int k = 0; k < 4; k++) exp_q.push_back(d[8*k +: 8]);
    end
    err_vis   = err_pend;
    stall_vis = stall_m;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  // Hold a word valid until the model says it was taken (bounded)
  task automatic send(input logic [31:0] d);
    int n = 0;
    do begin
      step(1'b1, d, 1'b0, 1'b0);
      n++;
    end while (!last_acc && n < 64);
    chk("send_accepted", {31'd0, last_acc}, 32'd1);
  endtask

  // Monitor: every falling edge compares the link and status outputs to the model
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("io_valid", {31'd0, io_valid_out}, {31'd0, (exp_q.size() != 0)});
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("io_data", {24'd0, io_data_out}, {24'd0, e});
          last_byte = e;
        end else begin
          chk("io_data_hold", {24'd0, io_data_out}, {24'd0, last_byte});
        end
        chk("credit_err", {31'd0, credit_err}, {31'd0, err_vis});
`ifdef BSG_UPSTREAM_TX_STALL_CNT_EN
        chk("stall_cnt", {16'd0, stall_cnt}, 32'(stall_vis));
`endif
      end
    end
  end

  initial begin
    rst           = 1'b1;
    core_valid_in = 1'b0;
    core_data_in  = 32'h0;
    io_token_in   = 1'b0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Reset state: ready low during reset, outputs cleared
    step(1'b0, 32'h0, 1'b0, 1'b1);
    chk("reset_valid", {31'd0, io_valid_out}, 32'd0);
    chk("reset_data", {24'd0, io_data_out}, 32'd0);
    chk("reset_err", {31'd0, credit_err}, 32'd0);

    // Single word, then back-to-back pair with valid held
    idle(1);
    send(32'hDDCCBBAA);
    idle(6);
    send(32'h03020100);
    send(32'h07060504);
    idle(6);

    // Random traffic with tokens returned only for outstanding words
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) < 70), $urandom(),
           (credits < CREDITS) && ($urandom_range(0, 99) < 25), 1'b0);
    end
    while (credits < CREDITS) step(1'b0, 32'h0, 1'b1, 1'b0);
    idle(6);

    // Credit exhaustion from a fresh reset, then stall at zero credit
    step(1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 300 && credits > 0; i++) step(1'b1, $urandom(), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 32'hA5A5A5A5, 1'b0, 1'b0);
`ifdef BSG_UPSTREAM_TX_STALL_CNT_EN
    chk("stall_cnt_10", {16'd0, stall_cnt}, 32'd10);
`endif
    // Token with valid held at zero credit: ready follows on the next cycle
    step(1'b1, 32'hA5A5A5A5, 1'b1, 1'b0);
    send(32'h5A5A5A5A);
    idle(6);

    // Bring credits to five, then accept and token together
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 32'h11223344, 1'b1, 1'b0);
    for (int i = 0; i < 40 && credits > 0; i++) step(1'b1, $urandom(), 1'b0, 1'b0);
    idle(6);

    // Refill, then one token too many sets the sticky error and leaves credits at full
    while (credits < CREDITS) step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    idle(2);
    chk("credit_err_sticky", {31'd0, credit_err}, 32'd1);
    for (int i = 0; i < 300 && credits > 0; i++) step(1'b1, $urandom(), 1'b0, 1'b0);
    idle(6);

    // Reset during beat 2 drops the rest of the word and restores credits
    step(1'b0, 32'h0, 1'b0, 1'b1);
    send(32'hCAFEF00D);
    idle(2);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    chk("midreset_valid", {31'd0, io_valid_out}, 32'd0);
    send(32'h89ABCDEF);
    idle(6);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
